// File: rtl/alu_share_ctrl.sv
// Two-port arbiter and sequencer for the shared 32-bit ALU: one operation in flight at a time.
// Optional macro DIV0_TRAP_EN: a divide with B==0 is answered at once with an error response.
module alu_share_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned SINGLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_sel,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_sel,
  output logic        req1_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_res,
  output logic        rsp_zero,
  output logic        rsp_err,
  input  logic        rsp_ready,
  output logic        busy
);

  localparam logic [3:0] SEL_MUL = 4'b0011;
  localparam logic [3:0] SEL_DIV = 4'b0100;
  localparam logic [3:0] CNT_MD  = 4'(MULDIV_CYCLES - 1);
  localparam logic [3:0] CNT_SC  = 4'(SINGLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic        r_id;
  logic [3:0]  r_cnt;
  logic [3:0]  r_sel;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_res;
  logic        r_zero;

  logic        w_g0;
  logic        w_g1;
  logic        w_accept;
  logic        w_capture;
  logic        w_done;
  logic        w_trap;
  logic        w_slow;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [3:0]  w_sel;

  // Round-robin: on a tie the port that did not win last time is granted.
  assign w_g0   = req0_valid & (~req1_valid | r_last);
  assign w_g1   = req1_valid & (~req0_valid | ~r_last);
  assign w_a    = w_g1 ? req1_a   : req0_a;
  assign w_b    = w_g1 ? req1_b   : req0_b;
  assign w_sel  = w_g1 ? req1_sel : req0_sel;
  assign w_slow = (w_sel == SEL_MUL) | (w_sel == SEL_DIV);

`ifdef DIV0_TRAP_EN
  assign w_trap = (w_sel == SEL_DIV) & (w_b == '0);
`else
  assign w_trap = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_g0 | w_g1) begin
          w_accept = 1'b1;
          w_next   = w_trap ? S_RESP : S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= w_a;
        r_b   <= w_b;
        r_sel <= w_sel;
        r_id  <= w_g1;
        r_cnt <= w_slow ? CNT_MD : CNT_SC;
      end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_res  <= alu_res;
        r_zero <= alu_zero;
      end else if (w_accept && w_trap) begin
        r_res  <= '1;
        r_zero <= 1'b0;
      end
      if (w_done) begin
        r_last <= r_id;
      end
    end
  end

`ifdef DIV0_TRAP_EN
  logic r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_trap;
    end
  end

  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;
`endif

  // Ready is masked during reset so every output reads 0 while reset is held.
  assign req0_ready = (r_state == S_IDLE) & ~reset & w_g0;
  assign req1_ready = (r_state == S_IDLE) & ~reset & w_g1;

  assign alu_a     = (r_state == S_EXEC) ? r_a   : '0;
  assign alu_b     = (r_state == S_EXEC) ? r_b   : '0;
  assign alu_sel   = (r_state == S_EXEC) ? r_sel : '0;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_id;
  assign rsp_res   = r_res;
  assign rsp_zero  = r_zero;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: vector table plus arbitration, backpressure and reset sequences.
module tb_alu_share_ctrl;

  localparam int unsigned MULDIV = 4;
  localparam int unsigned SINGLE = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_sel, req1_sel;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_sel;
  logic        alu_zero;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_ready, busy;
  logic [31:0] rsp_res;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.MULDIV_CYCLES(MULDIV), .SINGLE_CYCLES(SINGLE)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  // Behavioural ALU standing in for the shared unit.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    case (sel)
      4'b0000: return a & b;
      4'b0001: return a + b;
      4'b0010: return a - b;
      4'b0011: return a * b;
      4'b0100: return (b == 0) ? 32'd0 : a / b;
      4'b0101: return a | b;
      4'b0110: return a ^ b;
      4'b0111: return {31'd0, $signed(a) < $signed(b)};
      4'b1000: return a << b[4:0];
      4'b1001: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  assign alu_res  = alu_model(alu_a, alu_b, alu_sel);
  assign alu_zero = (alu_res == 32'd0);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {25'd0, rsp_valid, rsp_id, rsp_zero, rsp_err, busy, req0_ready, req1_ready}, 32'd0);
    check({tag, "_res"}, rsp_res, 32'd0);
    check({tag, "_alu_a"}, alu_a, 32'd0);
    check({tag, "_alu_b"}, alu_b, 32'd0);
    check({tag, "_alu_sel"}, {28'd0, alu_sel}, 32'd0);
  endtask

  typedef struct {
    logic        port;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int k;
    int ng, nr, last_acc;
    logic g_ids[4];

    vecs[0] = '{1'b0, 32'd5,          32'd7,        4'b0001, 32'd12,  1'b0, 1'b0, 2};
    vecs[1] = '{1'b1, 32'd6,          32'd7,        4'b0011, 32'd42,  1'b0, 1'b0, 5};
    vecs[2] = '{1'b0, 32'd3,          32'd3,        4'b0010, 32'd0,   1'b1, 1'b0, 2};
    vecs[3] = '{1'b1, 32'd100,        32'd7,        4'b0100, 32'd14,  1'b0, 1'b0, 5};
`ifdef DIV0_TRAP_EN
    vecs[4] = '{1'b0, 32'd9,          32'd0,        4'b0100, 32'hFFFFFFFF, 1'b0, 1'b1, 1};
`else
    vecs[4] = '{1'b0, 32'd9,          32'd0,        4'b0100, 32'd0,   1'b1, 1'b0, 5};
`endif
    vecs[5] = '{1'b1, 32'h000000F0,   32'h0000000F, 4'b0101, 32'hFF,  1'b0, 1'b0, 2};
    vecs[6] = '{1'b0, 32'd123,        32'd456,      4'b1111, 32'd0,   1'b1, 1'b0, 2};
    vecs[7] = '{1'b1, 32'hFFFFFFFF,   32'd1,        4'b0001, 32'd0,   1'b1, 1'b0, 2};

    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
    rsp_ready = 1'b1;
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    #1;

    // Vector table: one requester at a time, immediate response acceptance.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].port) begin
        req1_valid = 1'b1; req1_a = vecs[i].a; req1_b = vecs[i].b; req1_sel = vecs[i].sel;
      end else begin
        req0_valid = 1'b1; req0_a = vecs[i].a; req0_b = vecs[i].b; req0_sel = vecs[i].sel;
      end
      #1;
      check($sformatf("v%0d_ready", i), {30'd0, req1_ready, req0_ready}, vecs[i].port ? 32'd2 : 32'd1);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
        check($sformatf("v%0d_alu_sel", i), {28'd0, alu_sel}, {28'd0, vecs[i].sel});
        check($sformatf("v%0d_alu_a", i), alu_a, vecs[i].a);
        step();
        lat++;
      end
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_res", i), rsp_res, vecs[i].res);
      check($sformatf("v%0d_zero", i), {31'd0, rsp_zero}, {31'd0, vecs[i].zero});
      check($sformatf("v%0d_id", i), {31'd0, rsp_id}, {31'd0, vecs[i].port});
      check($sformatf("v%0d_err", i), {31'd0, rsp_err}, {31'd0, vecs[i].err});
      step();
    end

    // Both ports valid continuously: alternating grants, one bubble after each acceptance.
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_sel = 4'b0010;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd3; req1_sel = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    ng = 0; nr = 0; last_acc = -1;
    for (int cyc = 0; cyc < 80 && nr < 4; cyc++) begin
      if (req0_ready || req1_ready) begin
        check("rr_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
        if (ng < 4) g_ids[ng] = req1_ready;
        ng++;
        if (last_acc >= 0) check("rr_bubble", cyc - last_acc, 1);
      end
      if (rsp_valid) begin
        check("rr_zero", {31'd0, rsp_zero}, 32'd1);
        check("rr_rsp_id", {31'd0, rsp_id}, nr % 2);
        nr++;
        last_acc = cyc;
      end
      step();
      if (ng >= 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
    end
    check("rr_grants", ng, 4);
    check("rr_responses", nr, 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), {31'd0, g_ids[i]}, i % 2);

    // Backpressure: response held for 5 cycles with another request pending.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_sel = 4'b0001;
    #1;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_sel = 4'b0001;
    wait_rsp(k);
    check("bp_valid", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_hold_res", rsp_res, 32'd4);
      check("bp_hold_id", {31'd0, rsp_id}, 32'd0);
      check("bp_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    step();
    check("bp_idle", {31'd0, busy}, 32'd0);
    check("bp_next_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
    step();
    req1_valid = 1'b0;
    wait_rsp(k);
    check("bp_next_res", rsp_res, 32'd2);
    check("bp_next_id", {31'd0, rsp_id}, 32'd1);
    step();

    // Reset during the second EXEC cycle of a divide.
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd5; req0_sel = 4'b0100;
    #1;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_sel = 4'b0001;
    step();
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    req1_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (rsp_valid || busy) k++;
      step();
    end
    check("rst_no_rsp", k, 0);
    req0_valid = 1'b1; req0_a = 32'd8; req0_b = 32'd2; req0_sel = 4'b0001;
    req1_valid = 1'b1;
    #1;
    check("rst_tie_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(k);
    check("rst_after_res", rsp_res, 32'd10);
    check("rst_after_id", {31'd0, rsp_id}, 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
